// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled, LSB-first frames with DBITS data bits and SB_TICK-tick stop period.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             sample_tick,
    input  logic             rx,
    output logic [DBITS-1:0] data_out,
    output logic             data_ready,
    output logic             frame_error,
    output logic             parity_error,
    output logic [2:0]       fsm_state
);

    // The tick counter widens only when the stop period exceeds 16 ticks (2 stop bits).
    localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [TW-1:0]    tick_q;
    logic [NW-1:0]    bit_q;
    logic [DBITS-1:0] shreg;
    logic             par_err_q;
    logic             stop_done;
    logic             word_ok;
    logic             frame_bad;
    logic             par_bad;

    assign fsm_state = state;

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (sample_tick && tick_q == TW'(7)) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (sample_tick && tick_q == TW'(15) && bit_q == NW'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample_tick && tick_q == TW'(15)) state_next = STOP;
`endif
            STOP:  if (sample_tick && tick_q == TW'(SB_TICK - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the frame verdict is taken on the stop-bit sample tick.
    always_comb begin
        stop_done = (state == STOP) && sample_tick && (tick_q == TW'(SB_TICK - 1));
        word_ok   = stop_done && rx_s && !par_err_q;
        frame_bad = stop_done && !rx_s;
        par_bad   = stop_done && par_err_q;
    end

    // Synchronizer, counters, shift register and registered output pulses
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg        <= '0;
            data_out     <= '0;
            data_ready   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            data_ready   <= word_ok;
            frame_error  <= frame_bad;
            parity_error <= par_bad;
            if (word_ok) data_out <= shreg;

            case (state)
                IDLE: begin
                    tick_q <= '0;
                    bit_q  <= '0;
                end
                START: begin
                    if (sample_tick) tick_q <= (tick_q == TW'(7)) ? '0 : tick_q + 1'b1;
                    bit_q <= '0;
                end
                DATA: begin
                    if (sample_tick) begin
                        if (tick_q == TW'(15)) begin
                            tick_q <= '0;
                            shreg  <= {rx_s, shreg[DBITS-1:1]};
                            bit_q  <= bit_q + 1'b1;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) tick_q <= (tick_q == TW'(SB_TICK - 1)) ? '0 : tick_q + 1'b1;
                end
                default: begin
                    if (sample_tick) tick_q <= (tick_q == TW'(15)) ? '0 : tick_q + 1'b1;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit equals the XOR of the data bits.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else if (state == IDLE) begin
            par_err_q <= 1'b0;
        end else if (state == PARITY && sample_tick && tick_q == TW'(15)) begin
            par_err_q <= (rx_s != ^shreg);
        end
    end
`else
    assign par_err_q = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame driver, data_ready scoreboard, per-scenario tasks.
module tb_uart_receiver;

    localparam int DBITS   = 8;
    localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_TICKS = 8 + 16 * (DBITS + PBITS) + SB_TICK;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sample_tick = 1'b0;
    logic             rx = 1'b1;
    logic [DBITS-1:0] data_out;
    logic             data_ready;
    logic             frame_error;
    logic             parity_error;
    logic [2:0]       fsm_state;

    int tests_run = 0;
    int tests_failed = 0;
    int ready_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;
    int tick_div = 4;
    int tick_cnt = 0;
    logic prev_ready = 1'b0;
    logic [DBITS-1:0] exp_q[$];

    uart_receiver #(.DBITS(DBITS), .SB_TICK(SB_TICK)) dut (
        .clk_100MHz   (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .rx           (rx),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .fsm_state    (fsm_state)
    );

    // Clock and baud tick generation
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt    <= 0;
            sample_tick <= 1'b1;
        end else begin
            tick_cnt    <= tick_cnt + 1;
            sample_tick <= 1'b0;
        end
    end

    // Scoreboard and pulse counters
    always @(negedge clk) begin
        logic [DBITS-1:0] exp;
        if (reset_n) begin
            if (data_ready) begin
                ready_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: data_out=%h but no word was expected", data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (data_out !== exp) begin
                        tests_failed++;
                        $display("FAIL sb_data: data_out=%h expected=%h", data_out, exp);
                    end
                end
                tests_run++;
                if (prev_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ready_width: data_ready high %b on previous cycle, expected 0", prev_ready);
                end
            end
            if (frame_error) ferr_cnt++;
            if (parity_error) perr_cnt++;
            if (frame_error && parity_error) both_cnt++;
        end
        prev_ready = data_ready;
    end

    // Driver tasks
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_ticks(n);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_ok);
        drive_bit(1'b0, 16);
        for (int i = 0; i < DBITS; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit, 16);
`endif
        if (stop_ok) begin
            drive_bit(1'b1, SB_TICK);
        end else begin
            drive_bit(1'b0, 10);
            drive_bit(1'b1, SB_TICK);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d[DBITS-1:0];
    endfunction

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({data_out, data_ready, frame_error, parity_error, fsm_state} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%h rdy=%b ferr=%b perr=%b st=%0d expected all 0",
                     data_out, data_ready, frame_error, parity_error, fsm_state);
        end
        reset_n = 1'b1;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_basic();
        int r0 = ready_cnt, f0 = ferr_cnt, p0 = perr_cnt;
        tick_div = 52;
        drive_bit(1'b1, 2);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, even_par(8'hA5), 1'b1);
        drive_bit(1'b1, 2);
        tests_run++;
        if (ready_cnt - r0 !== 1) begin
            tests_failed++;
            $display("FAIL basic_ready: pulses=%0d expected 1", ready_cnt - r0);
        end
        tests_run++;
        if ((ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin
            tests_failed++;
            $display("FAIL basic_errors: error pulses=%0d expected 0", (ferr_cnt - f0) + (perr_cnt - p0));
        end
        tests_run++;
        if (data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_data: data_out=%h expected a5", data_out);
        end
        tick_div = 4;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_frame_error();
        int r0 = ready_cnt, f0 = ferr_cnt;
        send_frame(8'h5A, even_par(8'h5A), 1'b0);
        drive_bit(1'b1, 16);
        tests_run++;
        if (ferr_cnt - f0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_pulse: frame_error pulses=%0d expected 1", ferr_cnt - f0);
        end
        tests_run++;
        if (ready_cnt - r0 !== 0) begin
            tests_failed++;
            $display("FAIL ferr_ready: data_ready pulses=%0d expected 0", ready_cnt - r0);
        end
        tests_run++;
        if (data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL ferr_hold: data_out=%h expected a5", data_out);
        end
    endtask

    task automatic test_glitch();
        int r0 = ready_cnt, f0 = ferr_cnt, p0 = perr_cnt;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 16);
        tests_run++;
        if (fsm_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL glitch_idle: state=%0d expected 0", fsm_state);
        end
        tests_run++;
        if ((ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: pulses=%0d expected 0",
                     (ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0));
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, even_par(8'h3C), 1'b1);
        tests_run++;
        if (data_out !== 8'h3C) begin
            tests_failed++;
            $display("FAIL glitch_next: data_out=%h expected 3c", data_out);
        end
    endtask

    task automatic test_back_to_back();
        int r0 = ready_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, even_par(8'h00), 1'b1);
        send_frame(8'hFF, even_par(8'hFF), 1'b1);
        drive_bit(1'b1, 4);
        tests_run++;
        if (ready_cnt - r0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_ready: pulses=%0d expected 2", ready_cnt - r0);
        end
        tests_run++;
        if (data_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL b2b_data: data_out=%h expected ff", data_out);
        end
    endtask

    task automatic test_fast_tick();
        tick_div = 1;
        drive_bit(1'b1, 8);
        exp_q.push_back(8'h96);
        send_frame(8'h96, even_par(8'h96), 1'b1);
        drive_bit(1'b1, 8);
        tests_run++;
        if (data_out !== 8'h96) begin
            tests_failed++;
            $display("FAIL fast_data: data_out=%h expected 96", data_out);
        end
        tick_div = 4;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_break();
        int r0 = ready_cnt, f0 = ferr_cnt, p0 = perr_cnt;
        drive_bit(1'b0, 3 * FRAME_TICKS + 4);
        drive_bit(1'b1, 32);
        tests_run++;
        if (ferr_cnt - f0 !== 3) begin
            tests_failed++;
            $display("FAIL break_ferr: frame_error pulses=%0d expected 3", ferr_cnt - f0);
        end
        tests_run++;
        if ((ready_cnt - r0) + (perr_cnt - p0) !== 0) begin
            tests_failed++;
            $display("FAIL break_other: other pulses=%0d expected 0", (ready_cnt - r0) + (perr_cnt - p0));
        end
        tests_run++;
        if (fsm_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL break_idle: state=%0d expected 0", fsm_state);
        end
        exp_q.push_back(8'h42);
        send_frame(8'h42, even_par(8'h42), 1'b1);
        tests_run++;
        if (data_out !== 8'h42) begin
            tests_failed++;
            $display("FAIL break_recover: data_out=%h expected 42", data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h81;
        int r0, f0, p0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        rx = d[4];
        wait_ticks(8);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rx = 1'b1;
        r0 = ready_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        drive_bit(1'b1, 20);
        tests_run++;
        if (data_out !== 8'h00 || fsm_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL rstmid_clear: data_out=%h state=%0d expected 00/0", data_out, fsm_state);
        end
        tests_run++;
        if ((ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_pulses: pulses=%0d expected 0",
                     (ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0));
        end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, even_par(8'h7E), 1'b1);
        tests_run++;
        if (data_out !== 8'h7E) begin
            tests_failed++;
            $display("FAIL rstmid_next: data_out=%h expected 7e", data_out);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int r0 = ready_cnt, p0 = perr_cnt, b0 = both_cnt;
        logic [7:0] before = data_out;
        send_frame(8'h07, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        tests_run++;
        if (perr_cnt - p0 !== 1 || ready_cnt - r0 !== 0) begin
            tests_failed++;
            $display("FAIL par_bad: perr=%0d ready=%0d expected 1/0", perr_cnt - p0, ready_cnt - r0);
        end
        tests_run++;
        if (data_out !== before) begin
            tests_failed++;
            $display("FAIL par_hold: data_out=%h expected %h", data_out, before);
        end
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        tests_run++;
        if (data_out !== 8'h07) begin
            tests_failed++;
            $display("FAIL par_good: data_out=%h expected 07", data_out);
        end
        send_frame(8'h07, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        tests_run++;
        if (both_cnt - b0 !== 1) begin
            tests_failed++;
            $display("FAIL par_both: simultaneous pulses=%0d expected 1", both_cnt - b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_fast_tick();
        test_break();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d expected words never received, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DBITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, sample ticks per stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port sample_tick  input  1  16x-oversample enable, one-cycle pulse from the baud rate generator.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DBITS  last correctly received word.
REQ-008 SHALL have port data_ready  output  1  one-cycle pulse, new word on data_out.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch (constant 0 without UART_RX_PARITY_EN).

Function
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions use rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL advance the 4-bit tick counter and bit counter only in cycles with sample_tick high.
REQ-014 IDLE: on rx_s low (any cycle, tick or not), go to START with tick counter cleared.
REQ-015 START: at tick count 7 (mid start bit), if rx_s low go to DATA with counters cleared, else return to IDLE (glitch rejected, no output pulse).
REQ-016 DATA: at tick count 15, shift rx_s into the MSB of the shift register (LSB-first line order) and clear tick count; after the DBITS-th bit, go to PARITY if enabled, else STOP.
REQ-017 PARITY: at tick count 15, compare rx_s to even parity of the received bits; go to STOP.
REQ-018 STOP: at tick count SB_TICK-1, sample rx_s; then return to IDLE.
REQ-019 Stop sampled high, no parity error: load data_out with the shift register and pulse data_ready exactly one cycle, in the same cycle data_out changes.
REQ-020 Stop sampled low: pulse frame_error one cycle; data_out unchanged; data_ready not pulsed.
REQ-021 Parity mismatch with stop high: pulse parity_error one cycle; data_out unchanged; data_ready not pulsed.
REQ-022 Frame and parity error in the same frame: both pulses in the same cycle.
REQ-023 Back-to-back frames: a start edge in the cycle after returning to IDLE SHALL be accepted with no lost frame.
REQ-024 rx_s held low continuously (break): frame_error once per frame period; no lockup.
REQ-025 sample_tick high on every cycle SHALL be supported (no minimum tick spacing).

Reset
REQ-026 On reset_n low at a clock edge: state IDLE, counters 0, shift register 0, data_out 0, data_ready/frame_error/parity_error 0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abort the frame with no output pulse; reception resumes on the next start edge after reset_n is high.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit expected after the data bits, parity_error active.
REQ-029 Macro UART_RX_PARITY_EN undefined: PARITY state and checker removed, DATA goes directly to STOP, parity_error tied 0.

Verification
REQ-030 Tick every 52 cycles, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one data_ready pulse, data_out = 0xA5, no error pulses.
REQ-031 rx low for 3 tick periods then high -> no data_ready, no error pulses, FSM back in IDLE; a following 0x3C frame -> data_out = 0x3C.
REQ-032 Frame 0x5A with stop bit low -> frame_error pulse, data_out keeps previous 0xA5, no data_ready.
REQ-033 Frames 0x00 then 0xFF with no idle gap -> two data_ready pulses, data_out 0x00 then 0xFF.
REQ-034 reset_n low during data bit 4 of 0x81, then frame 0x7E -> no pulse for the aborted frame, data_out = 0 until 0x7E received.
REQ-035 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_error pulse, no data_ready; with parity bit 1 -> data_out = 0x07.
